cipher_aes_param: RTL and testbench

//  Round-iterative AES encryption core, one round per clock, for AES-128/192/256 selected at elaboration.

---
 rtl/cipher_aes_param.sv | 134 +++++++++++++
 tb/tb_cipher_aes_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cipher_aes_param.sv
// cipher_aes_param: one-round-per-clock AES-128/192/256 encryptor; define CIPHER_CT_CLEAR_EN to zero ciphertext whenever out_valid=0
module cipher_aes_param #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [127:0] plaintext,
    input  logic [127:0] round_ks,
    output logic         can_supply_last,
    output logic [3:0]   current_round,
    output logic [127:0] ciphertext,
    output logic         is_busy,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int NR = KEY_BITS == 128 ? 10 : KEY_BITS == 192 ? 12 : 14;
`ifdef CIPHER_CT_CLEAR_EN
    localparam logic CT_CLEAR = 1'b1;
`else
    localparam logic CT_CLEAR = 1'b0;
`endif

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $error("cipher_aes_param: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       st;
    logic [127:0] state_reg;
    logic [127:0] ct_q;
    logic [127:0] rnd;
    logic         last;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // inverse as x^254 = x^2 * x^4 * ... * x^128, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // byte i of the block sits at [127-8i -: 8], column-major (i = 4*col + row)
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   m [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            m[0] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            m[1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            m[2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
            m[3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
            for (int k = 0; k < 4; k++) o[127-8*(4*c+k) -: 8] = fin ? t[4*c+k] : m[k];
        end
        return o;
    endfunction

    always_comb begin
        last = (st == RUN) && (current_round == 4'(NR));
        rnd  = aes_round(state_reg, current_round == 4'(NR)) ^ round_ks;
    end

    assign can_supply_last = last;
    assign is_busy         = st != IDLE;
    assign ciphertext      = ct_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            current_round <= '0;
            state_reg     <= '0;
            ct_q          <= '0;
            out_valid     <= 1'b0;
        end else begin
            case (st)
                IDLE: if (en) begin
                    state_reg     <= plaintext ^ round_ks;
                    current_round <= 4'd1;
                    st            <= RUN;
                end
                RUN: begin
                    state_reg <= rnd;
                    if (last) begin
                        ct_q          <= rnd;
                        out_valid     <= 1'b1;
                        current_round <= '0;
                        st            <= DONE;
                    end else begin
                        current_round <= current_round + 4'd1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (CT_CLEAR) ct_q <= '0;
                    if (en) begin
                        state_reg     <= plaintext ^ round_ks;
                        current_round <= 4'd1;
                        st            <= RUN;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_aes_param.sv
// tb_cipher_aes_param: three cores (AES-128/192/256) driven from a table-based reference key schedule
module tb_cipher_aes_param;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] pt;
    logic         en   [3];
    logic         rdy  [3];
    logic [127:0] rks  [3];
    logic         csl  [3];
    logic         busy [3];
    logic         ov   [3];
    logic [3:0]   cr   [3];
    logic [127:0] ct   [3];
    logic [127:0] rk   [3][15];
    logic [127:0] exp_q [$];
    int           total = 0;
    int           bad = 0;

    logic [2047:0] sbox_t = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            assign rks[g] = rk[g][cr[g]];
            cipher_aes_param #(.KEY_BITS(128 + 64 * g)) dut (
                .clk(clk), .rst(rst), .en(en[g]), .plaintext(pt), .round_ks(rks[g]),
                .can_supply_last(csl[g]), .current_round(cr[g]), .ciphertext(ct[g]),
                .is_busy(busy[g]), .out_valid(ov[g]), .out_ready(rdy[g]));
        end
    endgenerate

    function automatic logic [31:0] sw(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox_t[2047 - 8 * int'(w[8*i +: 8]) -: 8];
        return o;
    endfunction

    task automatic expand(input int k);
        int          nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * k;
        nr = 10 + 2 * k;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[k][r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic start(input int k, input logic [127:0] want);
        en[k] = 1'b1;
        exp_q.push_back(want);
        @(negedge clk);
        en[k] = 1'b0;
    endtask

    // entered at the first falling edge after the start edge
    task automatic wait_done(input int k, input bit pulse);
        int n, nc;
        n = 0;
        nc = 0;
        while (ov[k] !== 1'b1 && n < 40) begin
            if (csl[k] === 1'b1) nc++;
`ifdef CIPHER_CT_CLEAR_EN
            check("ct_clear_run", ct[k], '0);
`endif
            if (pulse) en[k] = ~en[k];
            @(negedge clk);
            n++;
        end
        en[k] = 1'b0;
        check("latency", 128'(n), 128'(10 + 2 * k));
        check("csl_count", 128'(nc), 128'd1);
        check("busy_done", 128'(busy[k]), 128'd1);
        check("cr_done", 128'(cr[k]), 128'd0);
        check("ct", ct[k], exp_q.pop_front());
    endtask

    task automatic idle_check(input int k, input logic [127:0] last_ct);
        @(negedge clk);
        check("ov_idle", 128'(ov[k]), 128'd0);
        check("busy_idle", 128'(busy[k]), 128'd0);
        check("cr_idle", 128'(cr[k]), 128'd0);
`ifdef CIPHER_CT_CLEAR_EN
        check("ct_idle", ct[k], '0);
`else
        check("ct_idle", ct[k], last_ct);
`endif
    endtask

    initial begin
        rst = 1'b1;
        pt = PT;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0;
            rdy[k] = 1'b1;
            expand(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ov", 128'(ov[k]), 128'd0);
            check("rst_busy", 128'(busy[k]), 128'd0);
            check("rst_csl", 128'(csl[k]), 128'd0);
            check("rst_cr", 128'(cr[k]), 128'd0);
            check("rst_ct", ct[k], '0);
        end
        rst = 1'b0;
        @(negedge clk);
        start(0, CT128);
        wait_done(0, 1'b0);
        idle_check(0, CT128);
        start(1, CT192);
        wait_done(1, 1'b0);
        idle_check(1, CT192);
        start(2, CT256);
        wait_done(2, 1'b0);
        idle_check(2, CT256);
        rdy[0] = 1'b0;
        start(0, CT128);
        wait_done(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            en[0] = 1'b1;
            @(negedge clk);
            check("hold_ov", 128'(ov[0]), 128'd1);
            check("hold_ct", ct[0], CT128);
            check("hold_busy", 128'(busy[0]), 128'd1);
        end
        rdy[0] = 1'b1;
        exp_q.push_back(CT128);
        @(negedge clk);
        en[0] = 1'b0;
        check("b2b_ov", 128'(ov[0]), 128'd0);
        check("b2b_cr", 128'(cr[0]), 128'd1);
        wait_done(0, 1'b0);
        idle_check(0, CT128);
        start(0, CT128);
        repeat (4) @(negedge clk);
        check("mid_cr", 128'(cr[0]), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_ov", 128'(ov[0]), 128'd0);
        check("midrst_busy", 128'(busy[0]), 128'd0);
        check("midrst_cr", 128'(cr[0]), 128'd0);
        check("midrst_ct", ct[0], '0);
        @(negedge clk);
        start(0, CT128);
        wait_done(0, 1'b0);
        idle_check(0, CT128);
        start(0, CT128);
        wait_done(0, 1'b1);
        idle_check(0, CT128);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
